muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide unit with its own sequencer. It owns the HI/LO result registers. The main `controlador` FSM hands it operands from registers A/B with a Start pulse, then stalls on Busy. The CPU reads the results back through the MemParaReg mux (mfhi/mflo) and writes them directly for mthi/mtlo. Shift-add multiply and restoring divide share one 32-step counter.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each.
STEPS, WIDTH, iteration count of the RUN state.

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  request; sampled only in IDLE
OpDiv  in  1  0 = multiply, 1 = divide; sampled with Start
OpSigned  in  1  1 = signed (mult/div), 0 = unsigned (multu/divu); sampled with Start
OperandA  in  WIDTH  multiplicand / dividend
OperandB  in  WIDTH  multiplier / divisor
WrHi  in  1  mthi: load HI from WrData (IDLE only)
WrLo  in  1  mtlo: load LO from WrData (IDLE only)
WrData  in  WIDTH  data for mthi/mtlo
Busy  out  1  1 whenever state != IDLE
Done  out  1  one-cycle pulse in DONE state
DivZero  out  1  one-cycle pulse, coincident with Done, when a divide had divisor 0
Hi  out  WIDTH  HI register
Lo  out  WIDTH  LO register
Count  out  6  remaining RUN iterations, for debug/waveforms

Behaviour:
- Reset (Reset=0, async): state=IDLE; Hi, Lo, Count, all internal accumulators = 0; Busy, Done, DivZero = 0. Reset asserted mid-operation abandons the operation immediately and no Done is produced.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE:
  - On Start=1, latch OpDiv, OpSigned, OperandA, OperandB; next state PREP.
  - WrHi/WrLo load Hi/Lo at the same edge.
  - If WrHi/WrLo and Start occur together, both are honoured; the operation result later overwrites Hi/Lo.
- PREP:
  - Record result signs:
    - multiply: product sign = signA ^ signB;
    - divide: quotient sign = signA ^ signB, remainder sign = signA.
    - Signs apply only if OpSigned; otherwise 0.
  - Replace signed operands by their magnitudes.
  - Count = STEPS.
  - If OpDiv and OperandB == 0, go to DONE with the divzero flag set; otherwise go to RUN.
- RUN, one step per cycle, Count decrements each cycle, exit to FIX when Count reaches 1 → STEPS cycles total.
  - Multiply (64-bit product register, multiplier in the low half):
    - if bit0 = 1, add the multiplicand to the upper half, with carry;
    - shift the 65-bit value right 1.
  - Divide (restoring, 64-bit {rem, quo}):
    - shift left 1;
    - trial = rem − divisor;
    - if non-negative: rem = trial, quo[0] = 1.
- FIX:
  - Apply the recorded signs by two's-complement negation: 64-bit for the product; quotient and remainder separately.
  - Go to DONE.
- DONE:
  - Hi/Lo are written at the edge entering DONE:
    - multiply: Hi = product[63:32], Lo = product[31:0];
    - divide: Lo = quotient, Hi = remainder;
    - divide-by-zero: Hi/Lo unchanged.
  - Done=1 (and DivZero=1 if flagged) for exactly this one cycle.
  - Next state IDLE unconditionally.
- Latency, with the Start-sampling edge as edge 0:
  - PREP is cycle 1; RUN is cycles 2..33; FIX is cycle 34; DONE is cycle 35.
  - Divide-by-zero reaches DONE at cycle 2.
  - Busy = 1 in cycles 1..35.
- Start, WrHi and WrLo are ignored whenever state != IDLE, including the DONE cycle. The requester must wait for Busy = 0.
- Hi/Lo are held between operations and readable at all times. During PREP..FIX they show the previous values.
- Signed overflow −2^31 / −1: quotient wraps to 0x80000000, remainder 0; no flag.
- Signed −2^31 × −2^31 = 0x4000000000000000.
- Arithmetic is modulo 2^64 internally; there is no overflow output.

Test Plan:
- Reset released, Start with OpDiv=0, OpSigned=0, A=B=0xFFFFFFFF → Busy cycles 1..35; Done only at cycle 35; Hi=0xFFFFFFFE, Lo=0x00000001.
- Signed multiply A=0xFFFFFFFD (−3), B=5 → Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; then A=B=0x80000000 signed → Hi=0x40000000, Lo=0.
- Signed divide A=0xFFFFFFF9 (−7), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Unsigned divide of the same operands → Lo=0x7FFFFFFC, Hi=1.
- Preload Hi=0x11111111 via WrHi and Lo=0x22222222 via WrLo, then divide with B=0 → Done and DivZero at cycle 2, Busy cycles 1..2, Hi/Lo unchanged.
- Start pulsed again at cycles 5 and 35, and WrLo at cycle 10, during a multiply → all ignored; exactly one Done; Busy=0 at cycle 36; Start at cycle 36 is accepted.
- Reset pulsed low at cycle 20 of a multiply → Hi=Lo=0 and Busy=0 asynchronously; no Done; a new operation started after reset completes normally at its own cycle 35.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bus between the main controller and the multiply/divide
// sequencer. The controller is the master; the sequencer is the slave.
`timescale 1ns/1ps
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             OpDiv;
    logic             OpSigned;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
    logic             WrHi;
    logic             WrLo;
    logic [WIDTH-1:0] WrData;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic [5:0]       Count;

    modport master (
        output Start, OpDiv, OpSigned, OperandA, OperandB, WrHi, WrLo, WrData,
        input  Busy, Done, DivZero, Hi, Lo, Count
    );

    modport slave (
        input  Start, OpDiv, OpSigned, OperandA, OperandB, WrHi, WrLo, WrData,
        output Busy, Done, DivZero, Hi, Lo, Count
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide share one accumulator and one
// step counter; signs are stripped in PREP and re-applied in FIX.
`timescale 1ns/1ps
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int STEPS = WIDTH
) (
    input logic                 Clk,
    input logic                 Reset,
    muldiv_sequencer_if.slave   bus
);
    // Accumulator is one bit wider than the product so the restoring divide
    // can hold the shifted partial remainder without losing its top bit.
    localparam int AW = 2 * WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             op_div_q, op_div_d;
    logic             op_signed_q, op_signed_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             divzero_q, divzero_d;
    logic [5:0]       count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]     mul_sum;
    logic [AW-1:0]      mul_next;
    logic [AW-1:0]      div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic [AW-1:0]      div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] v,
                                                           input logic neg);
        return neg ? -v : v;
    endfunction

    // One iteration of each algorithm plus the sign fix-up, all combinational.
    always_comb begin
        mag_a     = magnitude(opa_q, op_signed_q);
        mag_b     = magnitude(opb_q, op_signed_q);

        // Multiply: conditional add into the upper half, then 65-bit shift right.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
        mul_next  = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

        // Divide: shift {rem, quo} left, trial-subtract divisor, keep if non-negative.
        div_shift = {acc_q[AW-2:0], 1'b0};
        div_trial = {1'b0, div_shift[AW-1:WIDTH]} - {2'b00, opb_q};
        div_next  = div_trial[WIDTH+1] ? div_shift
                                       : {div_trial[WIDTH:0], div_shift[WIDTH-1:1], 1'b1};

        prod_fix  = apply_sign_wide(acc_q[2*WIDTH-1:0], neg_lo_q);
        quo_fix   = apply_sign(acc_q[WIDTH-1:0], neg_lo_q);
        rem_fix   = apply_sign(acc_q[2*WIDTH-1:WIDTH], neg_hi_q);
    end

    // Sequencer next state and status outputs.
    always_comb begin
        state_d     = state_q;
        bus.Busy    = (state_q != S_IDLE);
        bus.Done    = (state_q == S_DONE);
        bus.DivZero = (state_q == S_DONE) && divzero_q;
        case (state_q)
            S_IDLE: if (bus.Start) state_d = S_PREP;
            S_PREP: state_d = (op_div_q && (opb_q == '0)) ? S_DONE : S_RUN;
            S_RUN:  if (count_q == 6'd1) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: operand capture, iteration, and HI/LO update.
    always_comb begin
        op_div_d    = op_div_q;
        op_signed_d = op_signed_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        divzero_d   = divzero_q;
        count_d     = count_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    op_div_d    = bus.OpDiv;
                    op_signed_d = bus.OpSigned;
                    opa_d       = bus.OperandA;
                    opb_d       = bus.OperandB;
                    divzero_d   = 1'b0;
                end
                // Direct writes land at the same edge; a concurrent operation
                // overwrites them when it finishes.
                if (bus.WrHi) hi_d = bus.WrData;
                if (bus.WrLo) lo_d = bus.WrData;
            end
            S_PREP: begin
                // Product and quotient sign share neg_lo; remainder follows dividend.
                neg_lo_d  = op_signed_q & (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]);
                neg_hi_d  = op_signed_q & opa_q[WIDTH-1];
                opa_d     = mag_a;
                opb_d     = mag_b;
                acc_d     = op_div_q ? {{(WIDTH+1){1'b0}}, mag_a}
                                     : {{(WIDTH+1){1'b0}}, mag_b};
                count_d   = 6'(STEPS);
                divzero_d = op_div_q && (opb_q == '0);
            end
            S_RUN: begin
                acc_d   = op_div_q ? div_next : mul_next;
                count_d = count_q - 6'd1;
            end
            S_FIX: begin
                if (op_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            op_div_q    <= 1'b0;
            op_signed_q <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            divzero_q   <= 1'b0;
            count_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            op_div_q    <= op_div_d;
            op_signed_q <= op_signed_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            divzero_q   <= divzero_d;
            count_q     <= count_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign bus.Hi    = hi_q;
    assign bus.Lo    = lo_q;
    assign bus.Count = count_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a vector table of multiply/divide cases
// plus hand-written sequences for divide-by-zero, ignored requests and reset.
`timescale 1ns/1ps
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W), .STEPS(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [W-1:0] mhi, mlo;

    typedef struct {
        logic         div;
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts an operation at the current negedge (sampled at edge 0) and follows
    // it cycle by cycle through the cycle after DONE. s1/s2/wl name cycles in
    // which a stray Start / WrLo is driven; 0 means none.
    task automatic run_op(input logic div, input logic sgn,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input logic edz, input int s1, input int s2, input int wl);
        int last, done_cnt, done_at, busy_bad, hold_bad, dz_ok, dz_stray;
        logic [W-1:0] hi_at, lo_at;
        logic [5:0] cnt2;
        last = edz ? 2 : 35;
        done_cnt = 0; done_at = -1; busy_bad = 0; hold_bad = 0;
        dz_ok = 0; dz_stray = 0; hi_at = '0; lo_at = '0; cnt2 = '0;
        bus.OpDiv    = div;
        bus.OpSigned = sgn;
        bus.OperandA = a;
        bus.OperandB = b;
        bus.Start    = 1'b1;
        @(posedge Clk);
        for (int k = 1; k <= last + 1; k++) begin
            @(negedge Clk);
            if (bus.Busy !== (k <= last)) busy_bad++;
            if (bus.Done === 1'b1) begin done_cnt++; done_at = k; end
            if (bus.DivZero === 1'b1) begin
                if (k == last && bus.Done === 1'b1) dz_ok++; else dz_stray++;
            end
            if (k < last && (bus.Hi !== mhi || bus.Lo !== mlo)) hold_bad++;
            if (k == last) begin hi_at = bus.Hi; lo_at = bus.Lo; end
            if (k == 2) cnt2 = bus.Count;
            bus.Start    = (k == s1 || k == s2);
            bus.OperandA = bus.Start ? 32'h0000_1234 : a;
            bus.OperandB = bus.Start ? 32'h0000_0003 : b;
            bus.WrLo     = (k == wl);
            bus.WrData   = 32'hDEAD_BEEF;
        end
        chk("busy_profile", busy_bad, 0);
        chk("done_count", done_cnt, 1);
        chk("done_cycle", done_at, last);
        chk("divzero_at_done", dz_ok, {31'd0, edz});
        chk("divzero_stray", dz_stray, 0);
        chk("hilo_hold", hold_bad, 0);
        chk("hi", hi_at, ehi);
        chk("lo", lo_at, elo);
        if (!edz) chk("count_first_run", cnt2, 32);
        mhi = ehi;
        mlo = elo;
    endtask

    initial begin
        int done_bad;
        vecs[0]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC};
        vecs[5]  = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{1'b1, 1'b0, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[7]  = '{1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{1'b0, 1'b0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[9]  = '{1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
        vecs[10] = '{1'b0, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        Reset = 1'b0;
        bus.Start = 1'b0; bus.OpDiv = 1'b0; bus.OpSigned = 1'b0;
        bus.OperandA = '0; bus.OperandB = '0;
        bus.WrHi = 1'b0; bus.WrLo = 1'b0; bus.WrData = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_divzero", bus.DivZero, 0);
        chk("rst_hi", bus.Hi, 0);
        chk("rst_lo", bus.Lo, 0);
        chk("rst_count", bus.Count, 0);
        Reset = 1'b1;
        mhi = '0;
        mlo = '0;

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].div, vecs[i].sgn, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, 1'b0, 0, 0, 0);

        // Preload HI/LO directly, then divide by zero leaves them untouched.
        bus.WrHi = 1'b1; bus.WrData = 32'h11111111;
        @(posedge Clk);
        @(negedge Clk);
        bus.WrHi = 1'b0; bus.WrLo = 1'b1; bus.WrData = 32'h22222222;
        @(posedge Clk);
        @(negedge Clk);
        bus.WrLo = 1'b0;
        chk("preload_hi", bus.Hi, 32'h11111111);
        chk("preload_lo", bus.Lo, 32'h22222222);
        mhi = 32'h11111111;
        mlo = 32'h22222222;
        run_op(1'b1, 1'b1, 32'h00000005, 32'h00000000,
               32'h11111111, 32'h22222222, 1'b1, 0, 0, 0);

        // Stray Start at cycles 5 and 35, WrLo at cycle 10: all ignored.
        run_op(1'b0, 1'b1, 32'h00000003, 32'h00000005,
               32'h00000000, 32'h0000000F, 1'b0, 5, 35, 10);
        // Started in cycle 36 of the previous operation.
        run_op(1'b0, 1'b0, 32'h00010000, 32'h00010000,
               32'h00000001, 32'h00000000, 1'b0, 0, 0, 0);

        // Reset asserted in cycle 20 of a multiply.
        done_bad = 0;
        bus.OpDiv = 1'b0; bus.OpSigned = 1'b0;
        bus.OperandA = 32'h00000009; bus.OperandB = 32'h00000009;
        bus.Start = 1'b1;
        @(posedge Clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            bus.Start = 1'b0;
            if (bus.Done === 1'b1) done_bad++;
        end
        #2 Reset = 1'b0;
        #1;
        chk("async_rst_busy", bus.Busy, 0);
        chk("async_rst_hi", bus.Hi, 0);
        chk("async_rst_lo", bus.Lo, 0);
        chk("async_rst_count", bus.Count, 0);
        repeat (3) begin
            @(negedge Clk);
            if (bus.Done === 1'b1 || bus.Busy !== 1'b0) done_bad++;
        end
        Reset = 1'b1;
        repeat (20) begin
            @(negedge Clk);
            if (bus.Done === 1'b1 || bus.Busy !== 1'b0) done_bad++;
        end
        chk("no_done_after_abort", done_bad, 0);
        mhi = '0;
        mlo = '0;
        run_op(1'b0, 1'b0, 32'h00000006, 32'h00000007,
               32'h00000000, 32'h0000002A, 1'b0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so a stuck design still reaches a verdict.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000ns");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
